// File: rtl/race_game_ctrl.sv
// Game-level controller behind the graphics stage: detects per-frame crashes and
// finish-line crossings, runs the START/PLAY/PAUSE/CRASH/FINISH state machine and a lap timer.
module race_game_ctrl #(
    parameter int FRAME_Y      = 481,
    parameter int CRASH_FRAMES = 3,
    parameter int HOLD_FRAMES  = 180,
    parameter int TIMER_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enter_key,
    input  logic               pause_key,
    input  logic               video_on,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               car_on,
    input  logic               road_on,
    input  logic               finish_line,
    output logic               game_reset,
    output logic               pause,
    output logic               start_en,
    output logic               crash_en,
    output logic               finish_en,
    output logic [TIMER_W-1:0] lap_frames,
    output logic               frame_tick,
    output logic [2:0]         dbg_state,
    output logic [3:0]         dbg_crash_cnt
);

    // Handshake-free block: key inputs are levels, acted on at their rising edge;
    // the frame tick is a single clk pulse per frame derived from the pixel coordinates.

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_PLAY   = 3'd1,
        S_PAUSE  = 3'd2,
        S_CRASH  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               enter_prev, pause_prev, match_d;
    logic               offroad_f, finish_f, offroad_d, finish_d;
    logic [3:0]         crash_cnt_q, crash_cnt_d;
    logic [9:0]         hold_q, hold_d;
    logic [TIMER_W-1:0] lap_d;
    logic [4:0]         crash_sum;
    logic               enter_edge, pause_edge, match, tick;

    assign enter_edge = enter_key & ~enter_prev;
    assign pause_edge = pause_key & ~pause_prev;
    assign match      = (pixel_y == 10'(FRAME_Y)) && (pixel_x == 10'd0);
    assign tick       = match & ~match_d;
    assign crash_sum  = {1'b0, crash_cnt_q} + 5'd1;

    assign dbg_state     = state_q;
    assign dbg_crash_cnt = crash_cnt_q;

    always_comb begin
        state_d     = state_q;
        crash_cnt_d = crash_cnt_q;
        hold_d      = hold_q;
        lap_d       = lap_frames;
        offroad_d   = offroad_f;
        finish_d    = finish_f;
        case (state_q)
            S_START: begin
                offroad_d = 1'b0;
                finish_d  = 1'b0;
                if (enter_edge) begin
                    state_d     = S_PLAY;
                    lap_d       = '0;
                    crash_cnt_d = '0;
                end
            end
            S_PLAY: begin
                if (video_on && car_on && !road_on)   offroad_d = 1'b1;
                if (video_on && car_on && finish_line) finish_d = 1'b1;
                if (tick) begin
                    // Flags are judged as accumulated over the frame, then cleared.
                    offroad_d   = 1'b0;
                    finish_d    = 1'b0;
                    crash_cnt_d = offroad_f ? crash_sum[3:0] : 4'd0;
                    if (offroad_f && (crash_sum >= 5'(CRASH_FRAMES))) begin
                        state_d = S_CRASH;
                        hold_d  = '0;
                    end else if (finish_f) begin
                        state_d = S_FINISH;
                        hold_d  = '0;
                    end else begin
                        if (lap_frames != '1) lap_d = lap_frames + 1'b1;
                        if (pause_edge) state_d = S_PAUSE;
                    end
                end else if (pause_edge) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause_edge) state_d = S_PLAY;
            end
            S_CRASH, S_FINISH: begin
                offroad_d = 1'b0;
                finish_d  = 1'b0;
                if (enter_edge) begin
                    state_d = S_START;
                end else if (tick) begin
                    if (hold_q == 10'(HOLD_FRAMES - 1)) state_d = S_START;
                    else hold_d = hold_q + 10'd1;
                end
            end
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_START;
            enter_prev  <= 1'b1;
            pause_prev  <= 1'b1;
            match_d     <= 1'b0;
            offroad_f   <= 1'b0;
            finish_f    <= 1'b0;
            crash_cnt_q <= '0;
            hold_q      <= '0;
            lap_frames  <= '0;
            frame_tick  <= 1'b0;
            game_reset  <= 1'b1;
            start_en    <= 1'b1;
            crash_en    <= 1'b0;
            finish_en   <= 1'b0;
            pause       <= 1'b0;
        end else begin
            state_q     <= state_d;
            enter_prev  <= enter_key;
            pause_prev  <= pause_key;
            match_d     <= match;
            offroad_f   <= offroad_d;
            finish_f    <= finish_d;
            crash_cnt_q <= crash_cnt_d;
            hold_q      <= hold_d;
            lap_frames  <= lap_d;
            frame_tick  <= tick;
            game_reset  <= (state_d == S_START);
            start_en    <= (state_d == S_START);
            crash_en    <= (state_d == S_CRASH);
            finish_en   <= (state_d == S_FINISH);
            pause       <= (state_d == S_PAUSE);
        end
    end

endmodule
